// File: rtl/axi_wr_seq.sv
// Table-driven AXI4 single-beat write sequencer: walks NUM_WR address/data table
// entries, issuing AW and W independently and waiting for each B before moving on.
module axi_wr_seq #(
  parameter int unsigned NUM_WR = 3,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  m00_axi_aclk,
  input  logic                  m00_axi_aresetn,
  input  logic                  m00_axi_init_axi_txn,
  output logic [IDX_W-1:0]      seq_idx,
  input  logic [ADDR_W-1:0]     seq_addr,
  input  logic [DATA_W-1:0]     seq_data,
  output logic [ID_W-1:0]       m00_axi_awid,
  output logic [ADDR_W-1:0]     m00_axi_awaddr,
  output logic [7:0]            m00_axi_awlen,
  output logic [2:0]            m00_axi_awsize,
  output logic [1:0]            m00_axi_awburst,
  output logic                  m00_axi_awlock,
  output logic [3:0]            m00_axi_awcache,
  output logic [2:0]            m00_axi_awprot,
  output logic [3:0]            m00_axi_awqos,
  output logic                  m00_axi_awvalid,
  input  logic                  m00_axi_awready,
  output logic [DATA_W-1:0]     m00_axi_wdata,
  output logic [DATA_W/8-1:0]   m00_axi_wstrb,
  output logic                  m00_axi_wlast,
  output logic                  m00_axi_wvalid,
  input  logic                  m00_axi_wready,
  input  logic [ID_W-1:0]       m00_axi_bid,
  input  logic [1:0]            m00_axi_bresp,
  input  logic                  m00_axi_bvalid,
  output logic                  m00_axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT_B, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_init_q;
  logic                r_init_qq;
  logic [IDX_W-1:0]    r_idx;
  logic [ID_W-1:0]     r_awid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [7:0]          r_err_cnt;

  logic w_start;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_issue_done;
  logic w_b_hs;
  logic w_b_err;
  logic w_last;

  assign w_start      = r_init_q & ~r_init_qq;
  assign w_aw_hs      = r_awvalid & m00_axi_awready;
  assign w_w_hs       = r_wvalid & m00_axi_wready;
  // Both channels finished once every still-pending valid handshakes this edge.
  assign w_issue_done = (~r_awvalid | m00_axi_awready) & (~r_wvalid | m00_axi_wready);
  assign w_b_hs       = r_bready & m00_axi_bvalid;
  assign w_b_err      = (m00_axi_bresp != 2'b00) | (m00_axi_bid != r_awid);
  assign w_last       = (r_idx == IDX_W'(NUM_WR - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_state_nxt = S_LOAD;
      S_LOAD:         w_state_nxt = S_ISSUE;
      S_ISSUE:        if (w_issue_done) w_state_nxt = S_WAIT_B;
      S_WAIT_B:       if (w_b_hs) w_state_nxt = w_last ? S_DONE : S_LOAD;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_init_q  <= 1'b0;
      r_init_qq <= 1'b0;
      r_idx     <= '0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_init_q  <= m00_axi_init_axi_txn;
      r_init_qq <= r_init_q;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_awaddr  <= seq_addr;
          r_wdata   <= seq_data;
          r_awid    <= ID_W'(r_idx);
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
        end
        S_ISSUE: begin
          if (w_aw_hs)      r_awvalid <= 1'b0;
          if (w_w_hs)       r_wvalid  <= 1'b0;
          if (w_issue_done) r_bready  <= 1'b1;
        end
        S_WAIT_B: begin
          if (w_b_hs) begin
            r_bready <= 1'b0;
            if (w_b_err) begin
              r_err <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_last) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign seq_idx         = r_idx;
  assign m00_axi_awid    = r_awid;
  assign m00_axi_awaddr  = r_awaddr;
  assign m00_axi_awlen   = 8'd0;
  assign m00_axi_awsize  = 3'($clog2(DATA_W / 8));
  assign m00_axi_awburst = 2'b01;
  assign m00_axi_awlock  = 1'b0;
  assign m00_axi_awcache = 4'b0011;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awqos   = 4'b0000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = '1;
  assign m00_axi_wlast   = r_wvalid;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = r_bready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_axi_wr_seq.sv
// Bench for axi_wr_seq: behavioural slave plus write-list model checked every cycle,
// with directed scenarios and randomized table/latency/error runs.
module tb_axi_wr_seq;
  localparam int NUM_WR = 3;
  localparam int IDX_W  = 4;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic [IDX_W-1:0]    seq_idx;
  logic [ADDR_W-1:0]   seq_addr;
  logic [DATA_W-1:0]   seq_data;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready = 1'b0;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready = 1'b0;
  logic [ID_W-1:0]     bid = '0;
  logic [1:0]          bresp = 2'b00;
  logic                bvalid = 1'b0;
  logic                bready;
  logic                busy;
  logic                done;
  logic                err;
  logic [7:0]          err_cnt;

  logic [ADDR_W-1:0] tbl_addr [16];
  logic [DATA_W-1:0] tbl_data [16];
  assign seq_addr = tbl_addr[seq_idx];
  assign seq_data = tbl_data[seq_idx];

  axi_wr_seq #(.NUM_WR(NUM_WR), .IDX_W(IDX_W), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n), .m00_axi_init_axi_txn(init),
    .seq_idx(seq_idx), .seq_addr(seq_addr), .seq_data(seq_data),
    .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
    .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awlock(awlock),
    .m00_axi_awcache(awcache), .m00_axi_awprot(awprot), .m00_axi_awqos(awqos),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave knobs and injected errors, set by the stimulus process
  int aw_lat = 0, w_lat = 0, b_lat = 0;
  bit bad_resp [NUM_WR];
  bit bad_id   [NUM_WR];

  // Model of the run: writes completed, handshake flags, status bits
  bit m_busy, m_done, m_err, m_aw_ok, m_w_ok, init_prev;
  int m_cnt, m_wr;
  int aw_c, w_c, b_c;
  bit prev_aw_wait, prev_w_wait;
  logic [ADDR_W-1:0] prev_awaddr;
  logic [ID_W-1:0]   prev_awid;
  logic [DATA_W-1:0] prev_wdata;
  int n_awv, n_wv;
  logic [35:0] aw_log[$];
  logic [31:0] w_log[$];

  always @(negedge clk) begin
    chk("aw_const", {awlen, awsize, awburst, awlock, awcache, awprot, awqos, wstrb},
        {8'h00, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 4'hF});
    if (!rst_n) begin
      chk("rst_out", {awvalid, wvalid, wlast, bready, busy, done, err, err_cnt, awid, seq_idx, awaddr, wdata}, '0);
      m_busy = 0; m_done = 0; m_err = 0; m_cnt = 0; m_wr = 0; m_aw_ok = 0; m_w_ok = 0;
      init_prev = 0; aw_c = 0; w_c = 0; b_c = 0; prev_aw_wait = 0; prev_w_wait = 0;
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = 1'($urandom_range(0, 1));
      bid     = 4'($urandom);
      bresp   = 2'($urandom);
    end else begin
      chk("status", {busy, done, err, err_cnt}, {m_busy, m_done, m_err, 8'(m_cnt)});
      if (m_busy) chk("seq_idx", seq_idx, 4'(m_wr));
      chk("bready", bready, m_busy && m_aw_ok && m_w_ok);
      chk("aw_extra", awvalid && (!m_busy || m_aw_ok), 0);
      chk("w_extra", wvalid && (!m_busy || m_w_ok), 0);
      chk("wlast", wlast, wvalid);
      if (prev_aw_wait) chk("aw_hold", {awvalid, awid, awaddr}, {1'b1, prev_awid, prev_awaddr});
      if (prev_w_wait)  chk("w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
      if (awvalid) chk("aw_payload", {awid, awaddr}, {4'(m_wr), tbl_addr[m_wr]});
      if (wvalid)  chk("w_payload", wdata, tbl_data[m_wr]);
      if (awvalid) n_awv++;
      if (wvalid)  n_wv++;

      // Slave responses for the coming edge
      if (aw_lat == 0) awready = 1;
      else if (awvalid) begin aw_c++; awready = (aw_c >= aw_lat); end
      else begin aw_c = 0; awready = 0; end
      if (w_lat == 0) wready = 1;
      else if (wvalid) begin w_c++; wready = (w_c >= w_lat); end
      else begin w_c = 0; wready = 0; end
      if (!bready) begin
        bvalid = 0; b_c = 0;
      end else if (!bvalid) begin
        b_c++;
        if (b_c > b_lat) begin
          bvalid = 1;
          bid    = bad_id[m_wr] ? 4'd5 : 4'(m_wr);
          bresp  = bad_resp[m_wr] ? 2'b10 : 2'b00;
        end
      end
      prev_aw_wait = awvalid && !awready; prev_awaddr = awaddr; prev_awid = awid;
      prev_w_wait  = wvalid && !wready;   prev_wdata  = wdata;

      // Model update for what the coming edge does
      if (init && !init_prev && !m_busy) begin
        m_busy = 1; m_done = 0; m_err = 0; m_cnt = 0; m_wr = 0; m_aw_ok = 0; m_w_ok = 0;
      end
      init_prev = init;
      if (awvalid && awready) begin m_aw_ok = 1; aw_log.push_back({awid, awaddr}); end
      if (wvalid && wready)   begin m_w_ok = 1;  w_log.push_back(wdata); end
      if (bvalid && bready) begin
        if (bad_resp[m_wr] || bad_id[m_wr]) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
        m_aw_ok = 0; m_w_ok = 0; m_wr++;
        if (m_wr == NUM_WR) begin m_busy = 0; m_done = 1; end
      end
    end
  end

  task automatic start_txn();
    @(negedge clk); #1 init = 0;
    @(negedge clk); #1 init = 1;
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!busy && c < 20) begin @(negedge clk); c++; end
    chk({tag, "_busy"}, busy, 1);
    c = 0;
    while (!done && c < 400) begin @(negedge clk); c++; end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic clear_errs();
    for (int i = 0; i < NUM_WR; i++) begin bad_resp[i] = 0; bad_id[i] = 0; end
  endtask

  initial begin
    int cnt;
    clear_errs();
    for (int i = 0; i < 16; i++) begin tbl_addr[i] = $urandom; tbl_data[i] = $urandom; end
    repeat (5) @(negedge clk);
    #1 rst_n = 1;

    // Nominal three-write table, always-ready slave
    tbl_addr[0] = 32'hE000A204; tbl_data[0] = 32'h0000FE01;
    tbl_addr[1] = 32'hE000A208; tbl_data[1] = 32'h0000FE01;
    tbl_addr[2] = 32'hE000A040; tbl_data[2] = 32'h00000001;
    @(negedge clk); #1 init = 1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!awvalid && cnt < 50);
    chk("t2_first_aw", cnt, 3);
    while (!done && cnt < 100) begin @(negedge clk); cnt++; end
    chk("t2_done_cycle", cnt, 11);
    chk("t2_err", {err, err_cnt}, 0);
    chk("t2_nwr", aw_log.size(), 3);
    chk("t2_aw0", aw_log[0], {4'd0, 32'hE000A204});
    chk("t2_aw1", aw_log[1], {4'd1, 32'hE000A208});
    chk("t2_aw2", aw_log[2], {4'd2, 32'hE000A040});
    chk("t2_w", {w_log[0], w_log[1], w_log[2]}, {32'h0000FE01, 32'h0000FE01, 32'h00000001});

    // Slow AW acceptance, immediate W
    aw_lat = 4; n_awv = 0; n_wv = 0;
    start_txn(); wait_done("t3");
    chk("t3_awv_cycles", n_awv, 12);
    chk("t3_wv_cycles", n_wv, 3);
    aw_lat = 0;

    // Bad response on write 1, bad ID on write 2
    bad_resp[1] = 1; bad_id[2] = 1; aw_log.delete();
    start_txn(); wait_done("t4");
    chk("t4_err", {err, err_cnt}, {1'b1, 8'd2});
    chk("t4_nwr", aw_log.size(), 3);
    clear_errs();

    // Start pulse inside ISSUE and a held level are both ignored
    bad_resp[0] = 1; aw_lat = 3; aw_log.delete();
    start_txn();
    cnt = 0;
    while (!awvalid && cnt < 20) begin @(negedge clk); cnt++; end
    #1 init = 0;
    @(negedge clk); #1 init = 1;
    wait_done("t5a");
    repeat (6) @(negedge clk);
    chk("t5_hold", {busy, done, err, err_cnt}, {1'b0, 1'b1, 1'b1, 8'd1});
    chk("t5_norestart", aw_log.size(), 3);
    clear_errs(); aw_lat = 0;
    start_txn();
    cnt = 0;
    while (!busy && cnt < 20) begin @(negedge clk); cnt++; end
    chk("t5_clr", {busy, done, err, err_cnt}, {1'b1, 1'b0, 1'b0, 8'd0});
    wait_done("t5b");

    // Asynchronous reset while waiting for B
    b_lat = 3;
    start_txn();
    cnt = 0;
    while (!bready && cnt < 50) begin @(negedge clk); cnt++; end
    chk("t6_reach_waitb", bready, 1);
    #2 rst_n = 0;
    #1 chk("t6_async", {awvalid, wvalid, bready, busy, done, err_cnt, seq_idx, awaddr}, '0);
    init = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1; b_lat = 0; aw_log.delete();
    start_txn(); wait_done("t6");
    chk("t6_nwr", aw_log.size(), 3);
    chk("t6_first_id", aw_log[0][35:32], 0);

    // Randomized tables, latencies and error injection
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) begin
        tbl_addr[i] = $urandom & 32'hFFFF_FFFC;
        tbl_data[i] = $urandom;
      end
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      for (int i = 0; i < NUM_WR; i++) begin
        bad_resp[i] = ($urandom_range(0, 3) == 0);
        bad_id[i]   = ($urandom_range(0, 3) == 0);
      end
      start_txn(); wait_done("rnd");
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
